// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the load-use / RAW hazard scoreboard.
// Each scoreboard entry describes one in-flight register writer at or beyond EX.
package hazard_scoreboard_pkg;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } sb_entry_t;

   localparam logic [1:0] WB_SEL_LOAD = 2'b00;

endpackage

// File: rtl/hazard_sb_match.sv
// Compares one scoreboard entry against the decode-stage source operands.
// IN_WINDOW is fixed at elaboration from the entry's distance past EX.
module hazard_sb_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int FORWARD_EN = 1,
   parameter bit IN_WINDOW  = 1'b1
) (
   input  sb_entry_t  entry,
   input  logic [4:0] rs1_addr,
   input  logic [4:0] rs2_addr,
   input  logic       rs1_used,
   input  logic       rs2_used,
   output logic       match
);

   logic rs1_hit;
   logic rs2_hit;
   logic kind_ok;

   always_comb begin
      rs1_hit = rs1_used && (entry.rd == rs1_addr);
      rs2_hit = rs2_used && (entry.rd == rs2_addr);
      // With forwarding, only loads are still unresolved inside the window
      kind_ok = (FORWARD_EN == 0) || entry.is_load;
      match   = IN_WINDOW && entry.valid && (entry.rd != 5'd0) && kind_ok
                && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / RAW hazard unit beside decode: shift-register scoreboard of
// in-flight writers from EX onward, stall/bubble generation and a stall counter.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int LOAD_LAT   = 1,
   parameter int WB_DIST    = 2,
   parameter int FORWARD_EN = 1,
   parameter int CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_rs1_addr_decode,
   input  logic [4:0]       i_rs2_addr_decode,
   input  logic             i_rs1_used_decode,
   input  logic             i_rs2_used_decode,
   input  logic [4:0]       i_rd_addr_decode,
   input  logic             i_rd_wren_decode,
   input  logic [1:0]       i_wb_sel_decode,
   input  logic             i_flush_branch,
   input  logic             i_mem_stall,
   output logic             o_stall,
   output logic             o_bubble,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam int D = (FORWARD_EN != 0) ? LOAD_LAT
                                        : ((LOAD_LAT > WB_DIST) ? LOAD_LAT : WB_DIST);
   localparam int W = (FORWARD_EN != 0) ? LOAD_LAT : WB_DIST;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

   // Valid bits are control and get reset; rd/is_load are payload qualified by valid
   logic             sb_vld_q [D];
   logic [4:0]       sb_rd_q  [D];
   logic             sb_ld_q  [D];
   sb_entry_t        sb       [D];
   logic [D-1:0]     match;
   logic             hazard;
   logic             new_vld;
   logic [CNT_W-1:0] stall_cnt_q;

   always_comb begin
      for (int k = 0; k < D; k++) begin
         sb[k] = '{valid: sb_vld_q[k], rd: sb_rd_q[k], is_load: sb_ld_q[k]};
      end
   end

   for (genvar k = 0; k < D; k++) begin : g_match
      hazard_sb_match #(
         .FORWARD_EN (FORWARD_EN),
         .IN_WINDOW  (k < W)
      ) u_match (
         .entry    (sb[k]),
         .rs1_addr (i_rs1_addr_decode),
         .rs2_addr (i_rs2_addr_decode),
         .rs1_used (i_rs1_used_decode),
         .rs2_used (i_rs2_used_decode),
         .match    (match[k])
      );
   end

   assign hazard   = |match;
   assign o_stall  = hazard & ~i_flush_branch & ~i_mem_stall;
   assign o_bubble = o_stall;
   // A flushed or held decode instruction enters EX as a bubble
   assign new_vld  = i_rd_wren_decode & ~i_flush_branch & ~hazard;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < D; k++) begin
            sb_vld_q[k] <= 1'b0;
         end
      end else if (!i_mem_stall) begin
         sb_vld_q[0] <= new_vld;
         for (int k = 1; k < D; k++) begin
            sb_vld_q[k] <= sb_vld_q[k-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_mem_stall) begin
         sb_rd_q[0] <= i_rd_addr_decode;
         sb_ld_q[0] <= (i_wb_sel_decode == WB_SEL_LOAD);
         for (int k = 1; k < D; k++) begin
            sb_rd_q[k] <= sb_rd_q[k-1];
            sb_ld_q[k] <= sb_ld_q[k-1];
         end
      end
   end

   // o_stall is already masked by i_mem_stall, so the counter freezes with the pipe
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         stall_cnt_q <= '0;
      end else if (o_stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_q <= stall_cnt_q + CNT_INC;
      end
   end

   assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: five parameter variants share one
// stimulus stream; each phase checks the variant it targets.
module tb_hazard_scoreboard;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       u1;
   logic       u2;
   logic [4:0] rd;
   logic       wren;
   logic [1:0] wbsel;
   logic       flush;
   logic       mstall;

   logic        st_a, bb_a, st_b, bb_b, st_c, bb_c, st_d, bb_d, st_e, bb_e;
   logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
   logic [1:0]  cnt_e;

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // a: defaults
   hazard_scoreboard u_a (
      .i_clk(clk), .i_reset(rst_n),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_decode(rd), .i_rd_wren_decode(wren), .i_wb_sel_decode(wbsel),
      .i_flush_branch(flush), .i_mem_stall(mstall),
      .o_stall(st_a), .o_bubble(bb_a), .o_stall_cnt(cnt_a));

   // b: three-cycle load latency
   hazard_scoreboard #(.LOAD_LAT(3)) u_b (
      .i_clk(clk), .i_reset(rst_n),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_decode(rd), .i_rd_wren_decode(wren), .i_wb_sel_decode(wbsel),
      .i_flush_branch(flush), .i_mem_stall(mstall),
      .o_stall(st_b), .o_bubble(bb_b), .o_stall_cnt(cnt_b));

   // c: no forwarding
   hazard_scoreboard #(.FORWARD_EN(0), .WB_DIST(2)) u_c (
      .i_clk(clk), .i_reset(rst_n),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_decode(rd), .i_rd_wren_decode(wren), .i_wb_sel_decode(wbsel),
      .i_flush_branch(flush), .i_mem_stall(mstall),
      .o_stall(st_c), .o_bubble(bb_c), .o_stall_cnt(cnt_c));

   // d: two-cycle load latency
   hazard_scoreboard #(.LOAD_LAT(2)) u_d (
      .i_clk(clk), .i_reset(rst_n),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_decode(rd), .i_rd_wren_decode(wren), .i_wb_sel_decode(wbsel),
      .i_flush_branch(flush), .i_mem_stall(mstall),
      .o_stall(st_d), .o_bubble(bb_d), .o_stall_cnt(cnt_d));

   // e: two-bit counter
   hazard_scoreboard #(.CNT_W(2)) u_e (
      .i_clk(clk), .i_reset(rst_n),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_decode(rd), .i_rd_wren_decode(wren), .i_wb_sel_decode(wbsel),
      .i_flush_branch(flush), .i_mem_stall(mstall),
      .o_stall(st_e), .o_bubble(bb_e), .o_stall_cnt(cnt_e));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns 1 time unit after the next rising edge, then inputs may change
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
      rd = 5'd0; wren = 1'b0; wbsel = 2'b01;
   endtask

   task automatic load(input logic [4:0] dst);
      nop();
      rd = dst; wren = 1'b1; wbsel = 2'b00;
   endtask

   task automatic alu(input logic [4:0] dst);
      nop();
      rd = dst; wren = 1'b1; wbsel = 2'b01;
   endtask

   task automatic use_rs(input logic [4:0] a1, input logic ua1, input logic [4:0] a2, input logic ua2);
      nop();
      rs1 = a1; u1 = ua1; rs2 = a2; u2 = ua2;
      rd = 5'd20; wren = 1'b1; wbsel = 2'b01;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      nop();
      flush = 1'b0; mstall = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; mstall = 1'b0;
      nop();
      tick();
      #2;
      chk("reset_stall", {31'd0, st_a}, 32'd0);
      chk("reset_bubble", {31'd0, bb_a}, 32'd0);
      chk("reset_cnt", {16'd0, cnt_a}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Classic load-use with a single bubble
      load(5'd5);
      tick();
      use_rs(5'd5, 1'b1, 5'd0, 1'b0);
      #2;
      chk("lu1_stall", {31'd0, st_a}, 32'd1);
      chk("lu1_bubble", {31'd0, bb_a}, 32'd1);
      tick();
      #2;
      chk("lu1_release", {31'd0, st_a}, 32'd0);
      chk("lu1_cnt", {16'd0, cnt_a}, 32'd1);
      tick();
      nop();
      tick();

      // Three-cycle load latency, consumer on rs2
      do_reset();
      load(5'd7);
      tick();
      use_rs(5'd0, 1'b0, 5'd7, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("ll3_stall", {31'd0, st_b}, 32'd1);
         chk("ll3_bubble", {31'd0, bb_b}, 32'd1);
         tick();
      end
      #2;
      chk("ll3_release", {31'd0, st_b}, 32'd0);
      chk("ll3_cnt", {16'd0, cnt_b}, 32'd3);
      tick();
      nop();
      tick();

      // No-forwarding ALU RAW, and x0 never hazards
      do_reset();
      alu(5'd9);
      tick();
      use_rs(5'd9, 1'b1, 5'd0, 1'b0);
      #2;
      chk("nf_stall0", {31'd0, st_c}, 32'd1);
      chk("fwd_alu_nostall", {31'd0, st_a}, 32'd0);
      tick();
      #2;
      chk("nf_stall1", {31'd0, st_c}, 32'd1);
      tick();
      #2;
      chk("nf_release", {31'd0, st_c}, 32'd0);
      chk("nf_cnt", {16'd0, cnt_c}, 32'd2);
      tick();
      load(5'd0);
      tick();
      use_rs(5'd0, 1'b1, 5'd0, 1'b1);
      #2;
      chk("x0_nf", {31'd0, st_c}, 32'd0);
      chk("x0_fwd", {31'd0, st_a}, 32'd0);
      tick();
      // Unused operand never stalls
      load(5'd11);
      tick();
      use_rs(5'd0, 1'b0, 5'd11, 1'b0);
      #2;
      chk("unused_op", {31'd0, st_a}, 32'd0);
      tick();
      nop();
      tick();

      // Flush in the hazard cycle suppresses the stall and kills the consumer
      do_reset();
      load(5'd4);
      tick();
      use_rs(5'd4, 1'b1, 5'd0, 1'b0);
      flush = 1'b1;
      #2;
      chk("flush_stall", {31'd0, st_a}, 32'd0);
      chk("flush_bubble", {31'd0, bb_a}, 32'd0);
      tick();
      flush = 1'b0;
      #2;
      chk("flush_next", {31'd0, st_a}, 32'd0);
      chk("flush_cnt", {16'd0, cnt_a}, 32'd0);
      tick();
      nop();
      tick();

      // Memory freeze in the middle of a two-cycle load stall
      do_reset();
      load(5'd3);
      tick();
      use_rs(5'd3, 1'b1, 5'd0, 1'b0);
      #2;
      chk("ms_stall0", {31'd0, st_d}, 32'd1);
      tick();
      mstall = 1'b1;
      flush = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("ms_frozen_stall", {31'd0, st_d}, 32'd0);
         tick();
         flush = 1'b0;
         #2;
         chk("ms_frozen_cnt", {16'd0, cnt_d}, 32'd1);
      end
      mstall = 1'b0;
      #2;
      chk("ms_resume_stall", {31'd0, st_d}, 32'd1);
      tick();
      #2;
      chk("ms_release", {31'd0, st_d}, 32'd0);
      chk("ms_cnt", {16'd0, cnt_d}, 32'd2);
      tick();
      nop();
      tick();

      // Counter saturation, then asynchronous reset during a stall
      do_reset();
      for (int p = 0; p < 4; p++) begin
         load(5'd1);
         tick();
         use_rs(5'd1, 1'b1, 5'd0, 1'b0);
         #2;
         chk("sat_stall", {31'd0, st_e}, 32'd1);
         tick();
         tick();
         #2;
         chk("sat_cnt", {30'd0, cnt_e}, (p < 3) ? (p + 1) : 32'd3);
      end
      load(5'd1);
      tick();
      use_rs(5'd1, 1'b1, 5'd0, 1'b0);
      #2;
      chk("arst_pre", {31'd0, st_e}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_stall", {31'd0, st_e}, 32'd0);
      chk("arst_bubble", {31'd0, bb_e}, 32'd0);
      chk("arst_cnt", {30'd0, cnt_e}, 32'd0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("arst_after", {31'd0, st_e}, 32'd0);
      tick();
      #2;
      chk("arst_no_residual", {31'd0, st_e}, 32'd0);
      chk("arst_cnt_hold", {30'd0, cnt_e}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use / RAW hazard unit for the 5-stage RV32I pipeline.
- Sits beside the decode stage and keeps its own shift-register scoreboard of in-flight register writers, from EX onward.
- Supports multi-cycle load latency and an optional no-forwarding mode.
- Drives the PC/IF-ID hold and the ID/EX bubble insert, and keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- LOAD_LAT, 1: cycles after EX before load data can be forwarded. 1 is the classic single-bubble case; must be ≥1.
- WB_DIST, 2: number of stages from EX up to, but not including, WB. The register file is write-before-read, so WB itself never causes a hazard. Must be ≥1.
- FORWARD_EN, 1: 1 means only loads can cause hazards. 0 means every writer causes a hazard until it reaches WB.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rs1_addr_decode  in  5  rs1 of the instruction in decode.
- i_rs2_addr_decode  in  5  rs2 of the instruction in decode.
- i_rs1_used_decode  in  1  instruction reads rs1.
- i_rs2_used_decode  in  1  instruction reads rs2.
- i_rd_addr_decode  in  5  rd of the instruction in decode.
- i_rd_wren_decode  in  1  instruction writes rd.
- i_wb_sel_decode  in  2  writeback select; 2'b00 means load.
- i_flush_branch  in  1  taken branch/jump resolved in EX; kills the instructions in IF and ID.
- i_mem_stall  in  1  global pipeline freeze caused by memory wait.
- o_stall  out  1  hold PC and IF/ID.
- o_bubble  out  1  insert a NOP into ID/EX.
- o_stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard depth D = FORWARD_EN ? LOAD_LAT : max(LOAD_LAT, WB_DIST).
- Each entry holds {valid, rd[4:0], is_load}. Entry 0 is the instruction currently in EX; entry k is k stages older.
- Hazard window W = FORWARD_EN ? LOAD_LAT : WB_DIST.
- Entry k matches when all of the following hold:
  - valid;
  - rd != 0;
  - k < W;
  - (FORWARD_EN == 0, or is_load);
  - (rd == rs1 and rs1_used) or (rd == rs2 and rs2_used).
- hazard = OR of all entry matches. Purely combinational from the registers and decode inputs, so the stall takes effect in the same cycle.
- o_stall = o_bubble = hazard & ~i_flush_branch & ~i_mem_stall.
- Shift rule at each clock edge, in priority order:
  1. i_mem_stall = 1: the scoreboard holds and the counter holds. This has priority over a flush arriving in the same cycle, because the whole pipe is frozen.
  2. i_flush_branch = 1: shift; entry 0 is loaded with a bubble (valid = 0).
  3. hazard = 1: shift; entry 0 is loaded with a bubble.
  4. Otherwise: shift; entry 0 is loaded with {i_rd_wren_decode, i_rd_addr_decode, i_wb_sel_decode == 2'b00}.
- On every shift, the oldest entry is discarded.
- Counter increments once per cycle in which o_stall = 1, and saturates at all ones without wrapping.
- Reset (asynchronous, active-low):
  - all entries invalid;
  - o_stall_cnt = 0;
  - o_stall and o_bubble therefore read 0.
  - Reset asserted mid-stall clears the scoreboard immediately; there is no residual stall after release.
- Every instruction leaves the window after W non-frozen cycles, so any stall lasts at most W cycles and the unit cannot deadlock.
- rd = x0 never creates a hazard. An instruction with rs*_used = 0 never stalls on that operand.

Decomposition:
- Shared package gets:
  - typedef sb_entry_t {valid, rd, is_load};
  - constant WB_SEL_LOAD = 2'b00.
- One natural sub-module: hazard_sb_match, which compares a single entry against rs1/rs2 and is instantiated D times via generate.
- Shift register and counter live in the top module.

Test Plan:
- Default params. Load x5 enters EX; next decode has rs1 = 5 → o_stall = 1 for exactly 1 cycle, then 0. o_stall_cnt = 1.
- LOAD_LAT = 3. Load x7, followed by an instruction using rs2 = 7 → stall for 3 consecutive cycles, 3 bubbles enter EX, o_stall_cnt = 3.
- FORWARD_EN = 0, WB_DIST = 2. ADD x9 followed by SUB using rs1 = 9 → 2 stall cycles. A load to x0 followed by a use of x0 → no stall.
- Load x4 in EX and a use of x4 in decode, with i_flush_branch = 1 in the same cycle → o_stall = 0; entry 0 becomes a bubble; no stall in the next cycle.
- LOAD_LAT = 2, mid-stall i_mem_stall = 1 for 4 cycles → o_stall = 0 and the counter frozen during the freeze. After release the remaining 1 stall cycle occurs, giving a total count of 2.
- CNT_W = 2, repeated load-use pairs → count saturates at 3. Assert i_reset = 0 during a stall → o_stall, o_bubble and o_stall_cnt drop to 0 asynchronously.
